// File: rtl/piece_sequencer.sv
// piece_sequencer: 7-bag tetromino randomizer with preview queue, hold slot and
// rotation tracking. Feeds type/rotation into the piece-shape ROM.
// Optional feature: define SEED_LOAD_EN to add seed_load/seed ports that reseed
// the LFSR and restart the fill sequence.
module piece_sequencer #(
  parameter int unsigned PREVIEW = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   spawn_req,
  input  logic                   hold_req,
  input  logic                   rot_cw,
  input  logic                   rot_ccw,
`ifdef SEED_LOAD_EN
  input  logic                   seed_load,
  input  logic [15:0]            seed,
`endif
  output logic                   ready,
  output logic [2:0]             cur_ptype,
  output logic [1:0]             rot_state,
  output logic [3*PREVIEW-1:0]   next_ptypes,
  output logic [2:0]             hold_ptype,
  output logic                   hold_valid,
  output logic                   hold_used,
  output logic [6:0]             bag_mask
);

  localparam logic [15:0] LfsrInit = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [0:0] {StFill, StReady} state_e;

  state_e                   state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [6:0]               mask_q, mask_d;
  logic [2:0]               cur_q, cur_d;
  logic [1:0]               rot_q, rot_d;
  logic [PREVIEW-1:0][2:0]  slots_q, slots_d;
  logic [2:0]               hold_q, hold_d;
  logic                     hold_valid_q, hold_valid_d;
  logic                     hold_used_q, hold_used_d;
  logic [2:0]               fill_cnt_q, fill_cnt_d;

  logic [2:0]  count;
  logic [2:0]  r;
  logic [2:0]  seen;
  logic [2:0]  draw_type;
  logic [6:0]  mask_after;
  logic [6:0]  mask_drawn;

  // Draw: pick the r-th remaining piece of the bag, reload the bag when emptied
  always_comb begin
    count = 3'd0;
    for (int i = 0; i < 7; i++) begin
      count = count + {2'b00, mask_q[i]};
    end
    r         = 3'(lfsr_q[7:0] % {5'd0, count});
    seen      = 3'd0;
    draw_type = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (mask_q[i]) begin
        if (seen == r) draw_type = 3'(i);
        seen = seen + 3'd1;
      end
    end
    mask_after = mask_q & ~(7'd1 << draw_type);
    mask_drawn = (mask_after == 7'd0) ? 7'h7F : mask_after;
  end

  // Next-state: fill sequencing, then spawn > hold > rotate command priority
  always_comb begin
    logic draw_en;
    logic advance;
    state_d      = state_q;
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
    cur_d        = cur_q;
    rot_d        = rot_q;
    slots_d      = slots_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_used_d  = hold_used_q;
    fill_cnt_d   = fill_cnt_q;
    draw_en      = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      StFill: begin
        draw_en = 1'b1;
        if (fill_cnt_q == 3'd0) cur_d = draw_type;
        for (int k = 0; k < int'(PREVIEW); k++) begin
          if (fill_cnt_q == 3'(k + 1)) slots_d[k] = draw_type;
        end
        fill_cnt_d = fill_cnt_q + 3'd1;
        if (fill_cnt_q == 3'(PREVIEW)) state_d = StReady;
      end
      StReady: begin
        if (spawn_req) begin
          advance     = 1'b1;
          rot_d       = 2'd0;
          hold_used_d = 1'b0;
        end else if (hold_req && !hold_used_q) begin
          rot_d       = 2'd0;
          hold_used_d = 1'b1;
          if (!hold_valid_q) begin
            hold_d       = cur_q;
            hold_valid_d = 1'b1;
            advance      = 1'b1;
          end else begin
            // Swap without touching the queue or the bag
            cur_d  = hold_q;
            hold_d = cur_q;
          end
        end else if (rot_cw ^ rot_ccw) begin
          rot_d = rot_cw ? rot_q + 2'd1 : rot_q - 2'd1;
        end
      end
      default: state_d = StFill;
    endcase

    if (advance) begin
      draw_en = 1'b1;
      cur_d   = slots_q[0];
      for (int k = 0; k < int'(PREVIEW) - 1; k++) begin
        slots_d[k] = slots_q[k + 1];
      end
      slots_d[PREVIEW-1] = draw_type;
    end

    mask_d = draw_en ? mask_drawn : mask_q;

`ifdef SEED_LOAD_EN
    // Reseed behaves like a reset apart from the LFSR value
    if (seed_load) begin
      lfsr_d       = (seed == 16'h0000) ? LfsrInit : seed;
      state_d      = StFill;
      mask_d       = 7'h7F;
      cur_d        = 3'd0;
      rot_d        = 2'd0;
      slots_d      = '0;
      hold_d       = 3'd0;
      hold_valid_d = 1'b0;
      hold_used_d  = 1'b0;
      fill_cnt_d   = 3'd0;
    end
`endif
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StFill;
      lfsr_q       <= LfsrInit;
      mask_q       <= 7'h7F;
      cur_q        <= 3'd0;
      rot_q        <= 2'd0;
      slots_q      <= '0;
      hold_q       <= 3'd0;
      hold_valid_q <= 1'b0;
      hold_used_q  <= 1'b0;
      fill_cnt_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      mask_q       <= mask_d;
      cur_q        <= cur_d;
      rot_q        <= rot_d;
      slots_q      <= slots_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_used_q  <= hold_used_d;
      fill_cnt_q   <= fill_cnt_d;
    end
  end

  assign ready       = (state_q == StReady);
  assign cur_ptype   = cur_q;
  assign rot_state   = rot_q;
  assign next_ptypes = slots_q;
  assign hold_ptype  = hold_q;
  assign hold_valid  = hold_valid_q;
  assign hold_used   = hold_used_q;
  assign bag_mask    = mask_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer (PREVIEW=3). Expected draws are worked out
// by hand from the LFSR sequence starting at 16'hACE1 (and 16'h1234 for reseed),
// with commands issued on consecutive edges so the LFSR value at each draw is known.
module tb_piece_sequencer;

  localparam int unsigned PREVIEW = 3;

  logic                 Clk;
  logic                 Reset;
  logic                 spawn_req;
  logic                 hold_req;
  logic                 rot_cw;
  logic                 rot_ccw;
`ifdef SEED_LOAD_EN
  logic                 seed_load;
  logic [15:0]          seed;
`endif
  logic                 ready;
  logic [2:0]           cur_ptype;
  logic [1:0]           rot_state;
  logic [3*PREVIEW-1:0] next_ptypes;
  logic [2:0]           hold_ptype;
  logic                 hold_valid;
  logic                 hold_used;
  logic [6:0]           bag_mask;

  int tests_run;
  int tests_failed;

  piece_sequencer #(.PREVIEW(PREVIEW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .spawn_req   (spawn_req),
    .hold_req    (hold_req),
    .rot_cw      (rot_cw),
    .rot_ccw     (rot_ccw),
`ifdef SEED_LOAD_EN
    .seed_load   (seed_load),
    .seed        (seed),
`endif
    .ready       (ready),
    .cur_ptype   (cur_ptype),
    .rot_state   (rot_state),
    .next_ptypes (next_ptypes),
    .hold_ptype  (hold_ptype),
    .hold_valid  (hold_valid),
    .hold_used   (hold_used),
    .bag_mask    (bag_mask)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected slots given as slot0, slot1, slot2
  task automatic check_state(input string tag, input int rdy, input int cur, input int rot,
                             input int s0, input int s1, input int s2, input int hold,
                             input int hv, input int hu, input int mask);
    check_eq({tag, ".ready"}, 32'(ready), 32'(rdy));
    check_eq({tag, ".cur"}, 32'(cur_ptype), 32'(cur));
    check_eq({tag, ".rot"}, 32'(rot_state), 32'(rot));
    check_eq({tag, ".next"}, 32'(next_ptypes), 32'({3'(s2), 3'(s1), 3'(s0)}));
    check_eq({tag, ".hold"}, 32'(hold_ptype), 32'(hold));
    check_eq({tag, ".hold_valid"}, 32'(hold_valid), 32'(hv));
    check_eq({tag, ".hold_used"}, 32'(hold_used), 32'(hu));
    check_eq({tag, ".mask"}, 32'(bag_mask), 32'(mask));
  endtask

  // Apply one command for exactly one edge, sample 1 time unit after it
  task automatic cmd(input logic s, input logic h, input logic cw, input logic ccw);
    spawn_req = s;
    hold_req  = h;
    rot_cw    = cw;
    rot_ccw   = ccw;
    @(posedge Clk);
    #1;
    spawn_req = 1'b0;
    hold_req  = 1'b0;
    rot_cw    = 1'b0;
    rot_ccw   = 1'b0;
  endtask

  // Rotation vector: {cw, ccw} and expected rot_state after the edge
  logic [1:0] rot_in  [8];
  int         rot_exp [8];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    spawn_req    = 1'b0;
    hold_req     = 1'b0;
    rot_cw       = 1'b0;
    rot_ccw      = 1'b0;
`ifdef SEED_LOAD_EN
    seed_load    = 1'b0;
    seed         = 16'h0000;
`endif

    rot_in[0] = 2'b01; rot_exp[0] = 3;
    rot_in[1] = 2'b01; rot_exp[1] = 2;
    rot_in[2] = 2'b01; rot_exp[2] = 1;
    rot_in[3] = 2'b10; rot_exp[3] = 2;
    rot_in[4] = 2'b10; rot_exp[4] = 3;
    rot_in[5] = 2'b10; rot_exp[5] = 0;
    rot_in[6] = 2'b10; rot_exp[6] = 1;
    rot_in[7] = 2'b11; rot_exp[7] = 1;

    repeat (3) @(posedge Clk);
    #1;
    check_state("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h7F);
    Reset = 1'b0;

    // Fill: draws 1,5,2,0 from LFSR ACE1,E270,7138,389C
    repeat (3) cmd(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fill.ready_low", 32'(ready), 32'd0);
    cmd(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("fill", 1, 1, 0, 5, 2, 0, 0, 0, 0, 'h58);

    // Three spawns complete the first bag: 3,6,4 then reload
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check_state("spawn1", 1, 5, 0, 2, 0, 3, 0, 0, 0, 'h50);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check_state("spawn2", 1, 2, 0, 0, 3, 6, 0, 0, 0, 'h10);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check_state("spawn3", 1, 0, 0, 3, 6, 4, 0, 0, 0, 'h7F);

    // Hold into empty slot advances the queue (draws 4)
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("hold_empty", 1, 3, 0, 6, 4, 4, 0, 1, 1, 'h6F);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("hold_again", 1, 3, 0, 6, 4, 4, 0, 1, 1, 'h6F);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check_state("spawn4", 1, 6, 0, 4, 4, 2, 0, 1, 0, 'h6B);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("hold_swap", 1, 0, 0, 4, 4, 2, 6, 1, 1, 'h6B);

    for (int i = 0; i < 8; i++) begin
      cmd(1'b0, 1'b0, rot_in[i][1], rot_in[i][0]);
      check_eq($sformatf("rot%0d", i), 32'(rot_state), 32'(rot_exp[i]));
    end

    // Spawn wins over a simultaneous rotate
    cmd(1'b1, 1'b0, 1'b1, 1'b0);
    check_state("spawn_rot", 1, 4, 0, 4, 2, 5, 6, 1, 0, 'h4B);
    // Spawn wins over a simultaneous hold
    cmd(1'b1, 1'b1, 1'b0, 1'b0);
    check_state("spawn_hold", 1, 4, 0, 2, 5, 3, 6, 1, 0, 'h43);

    // Mid-game reset, then refill while commands are asserted (ignored in fill)
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_state("midreset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h7F);
    Reset = 1'b0;
    repeat (4) cmd(1'b0, 1'b1, 1'b1, 1'b0);
    check_state("refill", 1, 1, 0, 5, 2, 0, 0, 0, 0, 'h58);

`ifdef SEED_LOAD_EN
    // Seed 1234 draws 3,2,1,5; loading it twice must repeat the sequence
    for (int n = 0; n < 2; n++) begin
      seed_load = 1'b1;
      seed      = 16'h1234;
      @(posedge Clk);
      #1;
      seed_load = 1'b0;
      check_state($sformatf("seedload%0d", n), 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h7F);
      repeat (4) cmd(1'b0, 1'b0, 1'b0, 1'b0);
      check_state($sformatf("seedfill%0d", n), 1, 3, 0, 2, 1, 5, 0, 0, 0, 'h51);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/piece_sequencer.md
# piece_sequencer

Upstream feeder for the piece-shape ROM. Chooses the active tetromino type (0–6) using a 7-bag randomizer, keeps a preview queue and a hold slot, and tracks the active piece's rotation state (0–3). Its `cur_ptype`/`rot_state` pair drives the shape lookup's type and rotation inputs. Game control issues spawn, hold and rotate commands.

## Interface
Parameters:
- `PREVIEW`, default 3: number of preview slots (1–4).

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `spawn_req`  in  1  single-cycle pulse: retire the active piece and advance the queue.
- `hold_req`  in  1  single-cycle pulse: hold/swap the active piece.
- `rot_cw`  in  1  rotate clockwise (+1 mod 4).
- `rot_ccw`  in  1  rotate counter-clockwise (−1 mod 4).
- `ready`  out  1  queue is filled and outputs are valid.
- `cur_ptype`  out  3  active piece type, 0–6.
- `rot_state`  out  2  active rotation index.
- `next_ptypes`  out  3*PREVIEW  preview slots; slot k is at bits [3k+2:3k], slot 0 is next.
- `hold_ptype`  out  3  held piece type.
- `hold_valid`  out  1  hold slot occupied.
- `hold_used`  out  1  hold already used since the last spawn.
- `bag_mask`  out  7  pieces remaining in the current bag; bit n represents type n.
- `seed_load`  in  1  present only with `SEED_LOAD_EN`.
- `seed`  in  16  present only with `SEED_LOAD_EN`.

## Operation
LFSR:
- 16-bit Galois LFSR, taps 0xB400, advances every cycle.
- Reset value is 16'hACE1.

Draw:
- `count` = popcount(`bag_mask`); r = `lfsr[7:0]` mod `count`.
- The drawn type is the r-th set bit of `bag_mask`, counted from bit 0 upward.
- The drawn bit is cleared. If the mask would become 0, it reloads to 7'h7F in the same cycle.
- At most one draw per cycle.

State machine:
- FILL (entered on reset): one draw per cycle.
  - Draw 1 goes to `cur_ptype`.
  - Draws 2 through PREVIEW+1 go to preview slots 0 through PREVIEW−1, in order.
  - After the last draw, go to READY.
- READY: `ready`=1. Commands are evaluated in this priority order:
  1. spawn,
  2. hold,
  3. rotate.
- While in FILL, all commands are ignored.

Spawn:
- `cur_ptype` ← slot 0; slots shift down; the last slot ← a new draw.
- `rot_state` ← 0; `hold_used` ← 0.

Hold (honoured only when `hold_used`=0 and `spawn_req`=0):
- Hold slot empty: `hold_ptype` ← cur, `hold_valid` ← 1, then the queue advances exactly as for a spawn.
- Hold slot occupied: swap cur and hold; no draw.
- In both cases: `rot_state` ← 0 and `hold_used` ← 1.
- A hold while `hold_used`=1 is ignored.

Rotate (only in a cycle with no spawn or accepted hold):
- `rot_cw` alone adds 1, wrapping 3→0.
- `rot_ccw` alone subtracts 1, wrapping 0→3.
- Both asserted: no change.

Reset values: `ready` 0, `cur_ptype` 0, `rot_state` 0, `next_ptypes` 0, `hold_ptype` 0, `hold_valid` 0, `hold_used` 0, `bag_mask` 7'h7F.

## Timing
- FILL begins in the first cycle with `Reset` low and makes draws in cycles 1 through PREVIEW+1. `ready` rises in cycle PREVIEW+2 (cycle 5 for PREVIEW=3).
- All outputs are registered. A command sampled on edge N is visible after edge N; there is no added latency.
- `Reset` asserted mid-operation returns everything to reset values on the next edge and refills from the bag.
- Each group of 7 consecutive draws, starting at the first draw after reset, is a permutation of 0–6.
- Draws that occur across a bag reload start a fresh permutation.

## Configuration
- `SEED_LOAD_EN` defined:
  - Adds the `seed_load` and `seed` ports.
  - `seed_load`=1 loads `seed` into the LFSR, or 16'hACE1 if `seed`=0. This overrides the advance for that cycle.
  - It also forces the state to FILL, resets `bag_mask` to 7'h7F, and clears the hold slot. The effect is the same as a reset, but with a new seed.
- `SEED_LOAD_EN` undefined: the ports are absent and the LFSR seeds only from its reset constant.

## Test plan
- Reset held 3 cycles, then released → `ready`=0, `cur_ptype`=0, `bag_mask`=7'h7F; `ready`=1 at cycle 5 with PREVIEW=3.
- 3 spawns after `ready` → the 7 draws (cur, three previews, three spawn draws) form a permutation of {0..6}; `bag_mask` then returns to 7'h7F.
- Hold with the slot empty → `hold_ptype`=old cur, `cur_ptype`=old slot 0, `hold_valid`=1, `hold_used`=1.
  - A second `hold_req` → no change.
  - Then a spawn, then hold → cur and hold swap with no draw.
- `rot_ccw` ×3 from 0 → 3, 2, 1; `rot_cw` from 3 → 0; `rot_cw`+`rot_ccw` together → unchanged; spawn → 0.
- `spawn_req` and `hold_req` in the same cycle → spawn only; `hold_used`=0.
- Reset asserted mid-game → all outputs at reset values next cycle. With `SEED_LOAD_EN`, loading `seed`=16'h1234 twice gives identical draw sequences.
